// File: rtl/div_share_ctrl_pkg.sv
// Shared types for the divider-sharing controller.
// Holds the FSM state encoding and the default geometry.
package div_share_ctrl_pkg;

   localparam int DIVS_NUM_REQ    = 2;
   localparam int DIVS_DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      DIVS_IDLE,
      DIVS_LAUNCH,
      DIVS_RUN,
      DIVS_RESP,
      DIVS_DRAIN
   } div_share_state_t;

endpackage

// File: rtl/div_share_ctrl_rr_arbiter2.sv
// Two-input round-robin arbiter with a combinational grant.
// The pointer only moves when both inputs contend and the grant is taken.
module rr_arbiter2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic       grant_idx
);

   logic ptr;
   logic both;

   assign both = &req;

   always_comb begin
      grant_idx = 1'b0;
      unique case (1'b1)
         both:              grant_idx = ptr;
         req[1] & ~req[0]:  grant_idx = 1'b1;
         default:           grant_idx = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr <= 1'b0;
      end else if (accept && both) begin
         ptr <= ~grant_idx;
      end
   end

endmodule

// File: rtl/div_share_ctrl.sv
// Shares one iterative divider between two ALU lanes.
// Grants round-robin, launches once, routes the result back to the owner lane.
module div_share_ctrl
   import div_share_ctrl_pkg::*;
#(
   parameter int NUM_REQ    = DIVS_NUM_REQ,
   parameter int DATA_WIDTH = DIVS_DATA_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_signed,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dividend,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_divisor,
   input  logic                          flush,
   output logic [NUM_REQ-1:0]            lane_pause,
   output logic [NUM_REQ-1:0]            resp_valid,
   output logic [DATA_WIDTH-1:0]         resp_quotient,
   output logic [DATA_WIDTH-1:0]         resp_remainder,
   output logic                          div_start,
   output logic                          div_op,
   output logic [DATA_WIDTH-1:0]         div_dividend,
   output logic [DATA_WIDTH-1:0]         div_divisor,
   input  logic                          div_running,
   input  logic                          div_done,
   input  logic [DATA_WIDTH-1:0]         div_quotient,
   input  logic [DATA_WIDTH-1:0]         div_remainder
);

   div_share_state_t state, state_n;

   logic                  owner;
   logic                  op_q;
   logic [DATA_WIDTH-1:0] dvd_q, dvs_q;
   logic [DATA_WIDTH-1:0] rq_q, rr_q;
   logic                  start_q;

   logic                  gidx;
   logic                  accept;
   logic                  capture;
   logic [DATA_WIDTH-1:0] sel_dvd, sel_dvs;
   logic                  unused_running;

   // The divider cannot be aborted; completion is tracked by div_done only.
   assign unused_running = div_running;

   assign accept  = (state == DIVS_IDLE) & ~flush & (|req_valid);
   assign capture = (state == DIVS_RUN) & div_done & ~flush;

   assign sel_dvd = req_dividend[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
   assign sel_dvs = req_divisor[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];

   rr_arbiter2 u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (req_valid[1:0]),
      .accept    (accept),
      .grant_idx (gidx)
   );

   always_comb begin
      state_n = state;
      unique case (state)
         DIVS_IDLE: begin
            if (accept) state_n = DIVS_LAUNCH;
         end
         DIVS_LAUNCH: begin
            state_n = flush ? DIVS_DRAIN : DIVS_RUN;
         end
         DIVS_RUN: begin
            if (div_done) begin
               state_n = flush ? DIVS_IDLE : DIVS_RESP;
            end else if (flush) begin
               state_n = DIVS_DRAIN;
            end
         end
         DIVS_RESP: begin
            state_n = DIVS_IDLE;
         end
         DIVS_DRAIN: begin
            if (div_done) state_n = DIVS_IDLE;
         end
         default: begin
            state_n = DIVS_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= DIVS_IDLE;
         owner   <= 1'b0;
         op_q    <= 1'b0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         rq_q    <= '0;
         rr_q    <= '0;
         start_q <= 1'b0;
      end else begin
         state   <= state_n;
         start_q <= (state_n == DIVS_LAUNCH);
         if (accept) begin
            owner <= gidx;
            op_q  <= req_signed[gidx];
            dvd_q <= sel_dvd;
            dvs_q <= sel_dvs;
         end
         if (capture) begin
            rq_q <= div_quotient;
            rr_q <= div_remainder;
         end
      end
   end

   // A flush landing in RESP swallows the pulse; the lane is being killed.
   always_comb begin
      resp_valid = '0;
      if ((state == DIVS_RESP) && !flush) begin
         resp_valid[owner] = 1'b1;
      end
   end

   assign lane_pause     = req_valid & ~resp_valid & {NUM_REQ{~flush}};
   assign resp_quotient  = rq_q;
   assign resp_remainder = rr_q;
   assign div_start      = start_q;
   assign div_op         = op_q;
   assign div_dividend   = dvd_q;
   assign div_divisor    = dvs_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Directed bench for div_share_ctrl with a fixed-latency divider model.
// Done arrives 33 cycles after the start cycle.
module tb_div_share_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid, req_signed;
   logic [63:0] req_dividend, req_divisor;
   logic        flush;
   logic [1:0]  lane_pause, resp_valid;
   logic [31:0] resp_quotient, resp_remainder;
   logic        div_start, div_op;
   logic [31:0] div_dividend, div_divisor;
   logic        m_busy, m_done;
   logic [5:0]  m_cnt;
   logic [31:0] m_q, m_r;

   int n_chk = 0;
   int n_fail = 0;
   int n_start = 0;
   int n_rv0 = 0;
   int n_rv1 = 0;

   always #5 clk = ~clk;

   div_share_ctrl #(.NUM_REQ(2), .DATA_WIDTH(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_signed     (req_signed),
      .req_dividend   (req_dividend),
      .req_divisor    (req_divisor),
      .flush          (flush),
      .lane_pause     (lane_pause),
      .resp_valid     (resp_valid),
      .resp_quotient  (resp_quotient),
      .resp_remainder (resp_remainder),
      .div_start      (div_start),
      .div_op         (div_op),
      .div_dividend   (div_dividend),
      .div_divisor    (div_divisor),
      .div_running    (m_busy),
      .div_done       (m_done),
      .div_quotient   (m_q),
      .div_remainder  (m_r)
   );

   // Behavioural divider
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_cnt  <= '0;
         m_q    <= '0;
         m_r    <= '0;
      end else begin
         m_done <= 1'b0;
         if (div_start) begin
            m_busy <= 1'b1;
            m_cnt  <= 6'd31;
            if (div_op) begin
               m_q <= 32'($signed(div_dividend) / $signed(div_divisor));
               m_r <= 32'($signed(div_dividend) % $signed(div_divisor));
            end else begin
               m_q <= div_dividend / div_divisor;
               m_r <= div_dividend % div_divisor;
            end
         end else if (m_busy) begin
            if (m_cnt == 6'd0) begin
               m_done <= 1'b1;
               m_busy <= 1'b0;
            end else begin
               m_cnt <= m_cnt - 6'd1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if (div_start)     n_start++;
         if (resp_valid[0]) n_rv0++;
         if (resp_valid[1]) n_rv1++;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int lane, input logic sgn,
                          input logic [31:0] a, input logic [31:0] b);
      req_valid[lane]            = 1'b1;
      req_signed[lane]           = sgn;
      req_dividend[lane*32 +: 32] = a;
      req_divisor[lane*32 +: 32]  = b;
   endtask

   // c0 is the cycle index of the next negedge; returns that index at resp
   task automatic wait_resp(input int lane, input int c0,
                            output int cyc, output logic pok);
      cyc = c0;
      pok = 1'b1;
      forever begin
         @(negedge clk);
         if (resp_valid[lane]) break;
         if (!lane_pause[lane]) pok = 1'b0;
         cyc++;
         if (cyc > 400) break;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int   cyc;
      logic pok;
      int   s0, r0;

      rst = 1'b1;
      req_valid = '0;
      req_signed = '0;
      req_dividend = '0;
      req_divisor = '0;
      flush = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_start", div_start, 0);
      chk("rst_rv", resp_valid, 0);
      chk("rst_pause", lane_pause, 0);
      chk("rst_dvd", div_dividend, 0);
      chk("rst_q", resp_quotient, 0);
      rst = 1'b0;

      // 1: single signed op, latency and pause
      @(posedge clk); #1;
      set_req(0, 1'b1, 32'd100, -32'sd7);
      @(negedge clk);
      chk("t1_pause_c0", lane_pause, 2'b01);
      chk("t1_start_c0", div_start, 0);
      @(negedge clk);
      chk("t1_start_c1", div_start, 1);
      chk("t1_op", div_op, 1);
      chk("t1_dvd", div_dividend, 100);
      chk("t1_dvs", div_divisor, 32'hFFFF_FFF9);
      wait_resp(0, 2, cyc, pok);
      chk("t1_lat", cyc, 35);
      chk("t1_pok", pok, 1);
      chk("t1_rv", resp_valid, 2'b01);
      chk("t1_q", resp_quotient, 32'hFFFF_FFF2);
      chk("t1_r", resp_remainder, 2);
      chk("t1_pause_resp", lane_pause, 2'b00);
      req_valid[0] = 1'b0;

      // 2: contention, rr order
      @(posedge clk); #1;
      set_req(0, 1'b1, 32'd7, 32'd2);
      set_req(1, 1'b0, 32'hFFFF_FFFF, 32'd16);
      wait_resp(0, 0, cyc, pok);
      chk("t2_lat0", cyc, 35);
      chk("t2_q0", resp_quotient, 3);
      chk("t2_r0", resp_remainder, 1);
      chk("t2_pause1", lane_pause[1], 1);
      req_valid[0] = 1'b0;
      wait_resp(1, 0, cyc, pok);
      chk("t2_lat1", cyc, 35);
      chk("t2_pok1", pok, 1);
      chk("t2_q1", resp_quotient, 32'h0FFF_FFFF);
      chk("t2_r1", resp_remainder, 15);
      req_valid[1] = 1'b0;
      @(posedge clk); #1;
      set_req(0, 1'b1, 32'd7, 32'd2);
      set_req(1, 1'b0, 32'd20, 32'd3);
      wait_resp(1, 0, cyc, pok);
      chk("t2b_lat1", cyc, 35);
      chk("t2b_q1", resp_quotient, 6);
      chk("t2b_r1", resp_remainder, 2);
      chk("t2b_rv", resp_valid, 2'b10);
      req_valid[1] = 1'b0;
      wait_resp(0, 0, cyc, pok);
      chk("t2b_lat0", cyc, 35);
      chk("t2b_q0", resp_quotient, 3);
      req_valid[0] = 1'b0;

      // 3: flush in RUN drains; waiting request launched after IDLE
      @(posedge clk); #1;
      set_req(0, 1'b0, 32'd50, 32'd5);
      s0 = n_start;
      r0 = n_rv0;
      repeat (6) @(posedge clk);
      #1;
      flush = 1'b1;
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("t3_rv_flush", resp_valid, 0);
      @(posedge clk); #1;
      flush = 1'b0;
      @(posedge clk); #1;
      set_req(1, 1'b0, 32'd9, 32'd3);
      wait_resp(1, 0, cyc, pok);
      chk("t3_lat", cyc, 62);
      chk("t3_pok", pok, 1);
      chk("t3_q", resp_quotient, 3);
      chk("t3_r", resp_remainder, 0);
      chk("t3_nstart", n_start - s0, 2);
      chk("t3_nrv0", n_rv0 - r0, 0);
      req_valid[1] = 1'b0;

      // 4a: flush coincident with done
      @(posedge clk); #1;
      set_req(0, 1'b1, 32'd40, 32'd4);
      r0 = n_rv0;
      repeat (34) @(posedge clk);
      #1;
      flush = 1'b1;
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("t4_done", m_done, 1);
      chk("t4_rv", resp_valid, 0);
      @(posedge clk); #1;
      flush = 1'b0;
      set_req(1, 1'b1, -32'sd9, 32'd2);
      @(negedge clk);
      chk("t4_idle_start", div_start, 0);
      chk("t4_idle_rv", resp_valid, 0);
      @(negedge clk);
      chk("t4_launch", div_start, 1);
      wait_resp(1, 2, cyc, pok);
      chk("t4_lat", cyc, 35);
      chk("t4_q", resp_quotient, 32'hFFFF_FFFC);
      chk("t4_r", resp_remainder, 32'hFFFF_FFFF);
      chk("t4_nrv0", n_rv0 - r0, 0);
      req_valid[1] = 1'b0;

      // 4b: flush during RESP suppresses the pulse
      @(posedge clk); #1;
      set_req(0, 1'b0, 32'd40, 32'd4);
      r0 = n_rv0;
      repeat (35) @(posedge clk);
      #1;
      flush = 1'b1;
      req_valid[0] = 1'b0;
      @(negedge clk);
      chk("t4b_rv", resp_valid, 0);
      chk("t4b_q", resp_quotient, 10);
      @(posedge clk); #1;
      flush = 1'b0;
      chk("t4b_nrv0", n_rv0 - r0, 0);

      // 5: async reset mid-RUN
      @(posedge clk); #1;
      set_req(0, 1'b1, 32'd77, 32'd7);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      req_valid = '0;
      #1;
      chk("t5_start", div_start, 0);
      chk("t5_op", div_op, 0);
      chk("t5_dvd", div_dividend, 0);
      chk("t5_dvs", div_divisor, 0);
      chk("t5_q", resp_quotient, 0);
      chk("t5_r", resp_remainder, 0);
      chk("t5_rv", resp_valid, 0);
      chk("t5_pause", lane_pause, 0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      set_req(0, 1'b1, 32'd9, 32'd3);
      wait_resp(0, 0, cyc, pok);
      chk("t5_lat", cyc, 35);
      chk("t5_q2", resp_quotient, 3);
      chk("t5_r2", resp_remainder, 0);

      // 6: back-to-back new op on the same lane
      set_req(0, 1'b1, -32'sd8, 32'd2);
      chk("t6_pause_resp", lane_pause[0], 0);
      wait_resp(0, 0, cyc, pok);
      chk("t6_lat", cyc, 35);
      chk("t6_pok", pok, 1);
      chk("t6_q", resp_quotient, 32'hFFFF_FFFC);
      chk("t6_r", resp_remainder, 0);
      req_valid[0] = 1'b0;
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
